// File: rtl/jfive_mmio_console.sv
// jfive_mmio_console: MMIO-fed per-channel byte FIFOs drained over a 64-bit Wishbone slave; optional JFIVE_CONSOLE_SIM_PRINT_EN echoes pushes in simulation
module jfive_mmio_console #(
  parameter int NUM_CH = 2,
  parameter int FIFO_AW = 4,
  parameter logic [15:0] MMIO_BASE = 16'h0100,
  parameter int WB_ADR_WIDTH = 4,
  parameter int WB_DAT_WIDTH = 64
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic                    mmio_wr,
  input  logic                    mmio_rd,
  input  logic [15:0]             mmio_addr,
  input  logic [3:0]              mmio_sel,
  input  logic [31:0]             mmio_wdata,
  output logic [31:0]             mmio_rdata,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  input  logic [7:0]              s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  output logic                    irq
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW = FIFO_AW + 1;
  logic [NUM_CH-1:0] en, ovf, push_req, push, pop, full, nonempty;
  logic [NUM_CH-1:0][CW-1:0] count;
  logic [NUM_CH-1:0][7:0] head;
  logic access, ctrl_wr;
  logic [WB_DAT_WIDTH-1:0] wb_rd;
  logic [31:0] mmio_rd_val;
  logic unused;
  assign unused = ^{s_wb_dat_i, s_wb_sel_i, mmio_sel, mmio_wdata};
  // A Wishbone access is taken in the cycle before ack rises, so it acts exactly once
  assign access = s_wb_stb_i && !s_wb_ack_o;
  assign ctrl_wr = access && s_wb_we_i && s_wb_adr_i == WB_ADR_WIDTH'(NUM_CH);
  assign irq = |(en & nonempty);
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic [7:0] mem [DEPTH];
      logic [FIFO_AW-1:0] wp, rp;
      logic [CW-1:0] cnt;
      assign count[g] = cnt;
      assign head[g] = mem[rp];
      assign full[g] = cnt == CW'(DEPTH);
      assign nonempty[g] = cnt != '0;
      assign push_req[g] = mmio_wr && mmio_sel[0] && mmio_addr == MMIO_BASE + 16'(4 * g);
      assign push[g] = push_req[g] && !full[g];
      assign pop[g] = access && !s_wb_we_i && s_wb_adr_i == WB_ADR_WIDTH'(g) && nonempty[g];
      // Storage array, unreset so it can map onto RAM
      always_ff @(posedge clk)
        if (push[g]) mem[wp] <= mmio_wdata[7:0];
      // Pointers wrap naturally; count tracks push/pop together
      always_ff @(posedge clk)
        if (!reset) begin
          wp <= '0;
          rp <= '0;
          cnt <= '0;
        end else begin
          wp <= wp + FIFO_AW'(push[g]);
          rp <= rp + FIFO_AW'(pop[g]);
          cnt <= cnt + CW'(push[g]) - CW'(pop[g]);
        end
    end
  endgenerate
  // Enables and sticky overflow; a same-cycle overflow beats the clear
  always_ff @(posedge clk)
    if (!reset) begin
      en <= '0;
      ovf <= '0;
    end else begin
      if (ctrl_wr && s_wb_sel_i[0]) en <= s_wb_dat_i[NUM_CH-1:0];
      ovf <= (ovf & ~((ctrl_wr && s_wb_sel_i[4]) ? s_wb_dat_i[32 +: NUM_CH] : '0)) | (push_req & full);
    end
  // Read muxes for both buses
  always_comb begin
    wb_rd = '0;
    mmio_rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_wb_adr_i == WB_ADR_WIDTH'(c)) begin
        wb_rd[7:0] = nonempty[c] ? head[c] : 8'h00;
        wb_rd[8] = nonempty[c];
        wb_rd[16 +: CW] = count[c];
      end
      if (mmio_addr == MMIO_BASE + 16'(4 * c)) mmio_rd_val = 32'(CW'(DEPTH) - count[c]);
    end
    if (s_wb_adr_i == WB_ADR_WIDTH'(NUM_CH)) begin
      wb_rd[NUM_CH-1:0] = en;
      wb_rd[32 +: NUM_CH] = ovf;
    end
    if (mmio_addr == MMIO_BASE + 16'h0080) mmio_rd_val = 32'(full);
  end
  // Registered bus responses
  always_ff @(posedge clk)
    if (!reset) begin
      mmio_rdata <= '0;
      s_wb_dat_o <= '0;
      s_wb_ack_o <= 1'b0;
    end else begin
      if (mmio_rd) mmio_rdata <= mmio_rd_val;
      if (access) s_wb_dat_o <= wb_rd;
      s_wb_ack_o <= access;
    end
`ifdef JFIVE_CONSOLE_SIM_PRINT_EN
  logic bol;
  // Simulation echo of accepted pushes, channel tag at the start of each line
  always_ff @(posedge clk)
    if (!reset) bol <= 1'b1;
    else
      for (int c = 0; c < NUM_CH; c++)
        if (push[c]) begin
          if (c > 0 && bol) $write("[%0d]", c);
          $write("%c", mmio_wdata[7:0]);
          bol <= mmio_wdata[7:0] == 8'h0a;
        end
`else
`endif
endmodule
